// File: rtl/esfa_pkg.sv
// Shared state encoding and vector-word field layout for the ESFA vector runner.
package esfa_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_APPLY  = 3'd2,
    S_SETTLE = 3'd3,
    S_CHECK  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam int MUT_BIT      = 0;
  localparam int EXP_BOOL_BIT = 1;
  localparam int EOP_BIT      = 2;
  localparam int FIELD_BASE   = 8;

  localparam int F_HANDLE   = 0;
  localparam int F_INDEX    = 1;
  localparam int F_VALUE    = 2;
  localparam int F_SELECTOR = 3;
  localparam int F_EXPECTED = 4;

  // Fields are DATA_W wide and packed upward from FIELD_BASE in the order above.
  function automatic int field_offset(input int k, input int data_w);
    return FIELD_BASE + k * data_w;
  endfunction

endpackage

// File: rtl/esfa_wait_counter.sv
// Loadable down-counter with a zero flag; times the ROM fetch and DUT settle waits.
module esfa_wait_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/esfa_vector_runner.sv
// ROM-driven self-test sequencer: fetches vectors, strobes them into the ESFA DUT,
// compares non-mutating results and keeps pass/fail counters and a first-failure capture.
module esfa_vector_runner
  import esfa_pkg::*;
#(
  parameter int              DATA_W     = 8,
  parameter int              ROM_W      = 64,
  parameter int              ADDR_W     = 32,
  parameter int              ADDR_STEP  = 8,
  parameter logic [ADDR_W-1:0] ADDR_LIMIT = 32'h0000_1000,
  parameter int              ROM_LAT    = 2,
  parameter int              DUT_LAT    = 1,
  parameter int              CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop_on_fail,
  input  logic              rom_busy,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [ROM_W-1:0]  rom_data,
  output logic [DATA_W-1:0] dut_handle,
  output logic [DATA_W-1:0] dut_index,
  output logic [DATA_W-1:0] dut_value,
  output logic [DATA_W-1:0] dut_selector,
  output logic              dut_valid,
  input  logic              dut_result_bool,
  input  logic [DATA_W-1:0] dut_result_value,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              overrun,
  output logic [CNT_W-1:0]  vec_count,
  output logic [CNT_W-1:0]  fail_count,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W:0]   fail_expected,
  output logic [DATA_W:0]   fail_actual,
  output logic [2:0]        state
);

  localparam int WAIT_W = 16;
  localparam int AW1    = ADDR_W + 1;
  localparam int OFF_H  = field_offset(F_HANDLE, DATA_W);
  localparam int OFF_I  = field_offset(F_INDEX, DATA_W);
  localparam int OFF_V  = field_offset(F_VALUE, DATA_W);
  localparam int OFF_S  = field_offset(F_SELECTOR, DATA_W);
  localparam int OFF_E  = field_offset(F_EXPECTED, DATA_W);

  state_t              state_q, state_next;
  logic                start_ok, wait_zero, wait_load, mismatch, addr_over, sof_q;
  logic                mut_q, exp_bool_q;
  logic [DATA_W-1:0]   exp_value_q;
  logic [AW1-1:0]      addr_next;
  logic [WAIT_W-1:0]   wait_value;
  logic                unused_rom;

  assign unused_rom = ^rom_data;

  // dut_valid is a one-cycle strobe with no back-pressure: the DUT always accepts
  // it, and its result is trusted from DUT_LAT cycles later until the next strobe.
  assign dut_valid = (state_q == S_APPLY);
  assign rom_en    = (state_q == S_FETCH);
  assign done      = (state_q == S_DONE);
  assign busy      = (state_q == S_FETCH) || (state_q == S_APPLY) ||
                     (state_q == S_SETTLE) || (state_q == S_CHECK);
  assign state     = state_q;

  assign mismatch  = !mut_q && ((dut_result_bool != exp_bool_q) ||
                                (dut_result_value != exp_value_q));
  assign addr_next = {1'b0, rom_addr} + AW1'(ADDR_STEP);
  assign addr_over = (addr_next >= {1'b0, ADDR_LIMIT});

  // Every state entry reloads the wait counter; only FETCH and SETTLE consume it.
  assign wait_load  = (state_next != state_q);
  assign wait_value = (state_next == S_FETCH) ? WAIT_W'(ROM_LAT - 1) : WAIT_W'(DUT_LAT - 1);

  esfa_wait_counter #(.W(WAIT_W)) u_wait (
    .clk        (clk),
    .reset      (reset),
    .load       (wait_load),
    .load_value (wait_value),
    .zero       (wait_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_next;
  end

  always_comb begin
    state_next = state_q;
    start_ok   = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start && !rom_busy) begin
          start_ok   = 1'b1;
          state_next = S_FETCH;
        end
      end
      S_FETCH:  if (wait_zero) state_next = rom_data[EOP_BIT] ? S_DONE : S_APPLY;
      S_APPLY:  state_next = S_SETTLE;
      S_SETTLE: if (wait_zero) state_next = S_CHECK;
      S_CHECK: begin
        if ((mismatch && sof_q) || addr_over) state_next = S_DONE;
        else                                  state_next = S_FETCH;
      end
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rom_addr      <= '0;
      dut_handle    <= '0;
      dut_index     <= '0;
      dut_value     <= '0;
      dut_selector  <= '0;
      mut_q         <= 1'b0;
      exp_bool_q    <= 1'b0;
      exp_value_q   <= '0;
      pass          <= 1'b0;
      overrun       <= 1'b0;
      sof_q         <= 1'b0;
      vec_count     <= '0;
      fail_count    <= '0;
      fail_addr     <= '0;
      fail_expected <= '0;
      fail_actual   <= '0;
    end else begin
      if (start_ok) begin
        rom_addr      <= '0;
        pass          <= 1'b1;
        overrun       <= 1'b0;
        sof_q         <= stop_on_fail;
        vec_count     <= '0;
        fail_count    <= '0;
        fail_addr     <= '0;
        fail_expected <= '0;
        fail_actual   <= '0;
      end
      if (state_q == S_FETCH && wait_zero && !rom_data[EOP_BIT]) begin
        dut_handle   <= rom_data[OFF_H +: DATA_W];
        dut_index    <= rom_data[OFF_I +: DATA_W];
        dut_value    <= rom_data[OFF_V +: DATA_W];
        dut_selector <= rom_data[OFF_S +: DATA_W];
        exp_value_q  <= rom_data[OFF_E +: DATA_W];
        exp_bool_q   <= rom_data[EXP_BOOL_BIT];
        mut_q        <= rom_data[MUT_BIT];
      end
      if (state_q == S_CHECK) begin
        if (vec_count != '1) vec_count <= vec_count + CNT_W'(1);
        if (mismatch) begin
          if (fail_count != '1) fail_count <= fail_count + CNT_W'(1);
          pass <= 1'b0;
          if (fail_count == '0) begin
            fail_addr     <= rom_addr;
            fail_expected <= {exp_bool_q, exp_value_q};
            fail_actual   <= {dut_result_bool, dut_result_value};
          end
        end
        if (!(mismatch && sof_q)) begin
          if (addr_over) begin
            overrun <= 1'b1;
            pass    <= 1'b0;
          end else begin
            rom_addr <= addr_next[ADDR_W-1:0];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_esfa_vector_runner.sv
// Bench for esfa_vector_runner: two instances (default latencies, and ROM_LAT=3/DUT_LAT=2
// with a 0x20 address limit) driven from ROM images checked against a run-level model.
module tb_esfa_vector_runner;

  localparam int          RL0 = 2, RL1 = 3, DL0 = 1, DL1 = 2;
  localparam logic [31:0] LIM0 = 32'h0000_1000, LIM1 = 32'h0000_0020;
  localparam logic [63:0] GARBAGE = 64'h5A5A_5A5A_5A5A_5A5A;

  typedef struct {
    int          cycles;
    int          vecs;
    int          fails;
    int          pulses;
    bit          pass;
    bit          overrun;
    logic [31:0] faddr;
    logic [8:0]  fexp;
    logic [8:0]  fact;
  } res_t;

  logic        clk, reset;
  logic        start [2], stop_on_fail [2], rom_busy [2];
  logic        rom_en [2], dut_valid [2], res_bool [2];
  logic        busy [2], done [2], pass [2], overrun [2];
  logic [31:0] rom_addr [2], fail_addr [2];
  logic [63:0] rom_data [2];
  logic [7:0]  dut_handle [2], dut_index [2], dut_value [2], dut_selector [2], res_value [2];
  logic [15:0] vec_count [2], fail_count [2];
  logic [8:0]  fail_expected [2], fail_actual [2];
  logic [2:0]  state [2];

  logic [63:0] mem [2][64];
  logic [63:0] rom_pipe [2][2];
  logic [9:0]  dsh [2][2];
  logic [8:0]  hold [2];
  logic [63:0] mon_w;
  int          pulses [2] = '{0, 0};
  int          stim_bad [2] = '{0, 0};
  int          checks = 0, failures = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : gen_dut
    esfa_vector_runner #(
      .ROM_LAT    (g == 0 ? RL0 : RL1),
      .DUT_LAT    (g == 0 ? DL0 : DL1),
      .ADDR_LIMIT (g == 0 ? LIM0 : LIM1)
    ) u_dut (
      .clk              (clk),
      .reset            (reset),
      .start            (start[g]),
      .stop_on_fail     (stop_on_fail[g]),
      .rom_busy         (rom_busy[g]),
      .rom_en           (rom_en[g]),
      .rom_addr         (rom_addr[g]),
      .rom_data         (rom_data[g]),
      .dut_handle       (dut_handle[g]),
      .dut_index        (dut_index[g]),
      .dut_value        (dut_value[g]),
      .dut_selector     (dut_selector[g]),
      .dut_valid        (dut_valid[g]),
      .dut_result_bool  (res_bool[g]),
      .dut_result_value (res_value[g]),
      .busy             (busy[g]),
      .done             (done[g]),
      .pass             (pass[g]),
      .overrun          (overrun[g]),
      .vec_count        (vec_count[g]),
      .fail_count       (fail_count[g]),
      .fail_addr        (fail_addr[g]),
      .fail_expected    (fail_expected[g]),
      .fail_actual      (fail_actual[g]),
      .state            (state[g])
    );
  end

  // Stand-in ESFA function: {bool, value} computed from the applied stimulus.
  function automatic logic [8:0] dut_fn(input logic [7:0] h, i, v, s);
    logic [7:0] val;
    val = (h ^ s) + 8'(i * 3) + v;
    return {h > i, val};
  endfunction

  // ROM with ROM_LAT-1 register stages, and DUT with DUT_LAT stages plus hold.
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      rom_pipe[g][0] <= rom_en[g] ? mem[g][rom_addr[g][8:3]] : GARBAGE;
      rom_pipe[g][1] <= rom_pipe[g][0];
      dsh[g][0] <= {dut_valid[g], dut_fn(dut_handle[g], dut_index[g], dut_value[g], dut_selector[g])};
      dsh[g][1] <= dsh[g][0];
    end
    if (dsh[0][0][9] === 1'b1) hold[0] <= dsh[0][0][8:0];
    if (dsh[1][1][9] === 1'b1) hold[1] <= dsh[1][1][8:0];
  end
  assign rom_data[0] = rom_pipe[0][0];
  assign rom_data[1] = rom_pipe[1][1];
  assign {res_bool[0], res_value[0]} = (dsh[0][0][9] === 1'b1) ? dsh[0][0][8:0] : hold[0];
  assign {res_bool[1], res_value[1]} = (dsh[1][1][9] === 1'b1) ? dsh[1][1][8:0] : hold[1];

  // Stimulus monitor: each strobe must carry the fields of the vector being run.
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (dut_valid[g] === 1'b1) begin
        pulses[g]++;
        mon_w = mem[g][rom_addr[g][8:3]];
        if ({dut_handle[g], dut_index[g], dut_value[g], dut_selector[g]} !==
            {mon_w[8+:8], mon_w[16+:8], mon_w[24+:8], mon_w[32+:8]}) stim_bad[g]++;
      end
    end
  end

  // ---------------- scoreboard / model ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  function automatic res_t model(input int g, input bit sof);
    res_t r;
    int a, rl, dl, lim;
    logic [63:0] w;
    logic [8:0] act, want;
    rl  = (g == 0) ? RL0 : RL1;
    dl  = (g == 0) ? DL0 : DL1;
    lim = (g == 0) ? int'(LIM0) : int'(LIM1);
    r = '{default: 0};
    r.pass = 1'b1;
    a = 0;
    for (int k = 0; k < 64; k++) begin
      w = mem[g][a / 8];
      r.cycles += rl;
      if (w[2]) break;
      r.pulses++;
      r.vecs++;
      r.cycles += dl + 2;
      if (!w[0]) begin
        act  = dut_fn(w[8+:8], w[16+:8], w[24+:8], w[32+:8]);
        want = {w[1], w[40+:8]};
        if (act != want) begin
          if (r.fails == 0) begin r.faddr = a; r.fexp = want; r.fact = act; end
          r.fails++;
          r.pass = 1'b0;
          if (sof) break;
        end
      end
      a += 8;
      if (a >= lim) begin r.overrun = 1'b1; r.pass = 1'b0; break; end
    end
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  function automatic logic [63:0] mk(input bit mut, eop, input logic [7:0] h, i, v, s,
                                     input bit eb, input logic [7:0] ev);
    logic [63:0] w;
    w = {$urandom(), $urandom()};
    w[0] = mut; w[1] = eb; w[2] = eop;
    w[8+:8] = h; w[16+:8] = i; w[24+:8] = v; w[32+:8] = s; w[40+:8] = ev;
    return w;
  endfunction

  function automatic logic [63:0] good(input bit mut);
    logic [7:0] h, i, v, s;
    logic [8:0] r;
    h = 8'($urandom); i = 8'($urandom); v = 8'($urandom); s = 8'($urandom);
    r = dut_fn(h, i, v, s);
    return mk(mut, 1'b0, h, i, v, s, r[8], r[7:0]);
  endfunction

  task automatic fill_eop(input int g);
    for (int k = 0; k < 64; k++) mem[g][k] = mk(1'b0, 1'b1, 0, 0, 0, 0, 1'b0, 0);
  endtask

  task automatic run(input int g, input bit sof, input string tag);
    res_t m;
    int n, nb, p0, b0;
    m  = model(g, sof);
    p0 = pulses[g];
    b0 = stim_bad[g];
    @(negedge clk);
    stop_on_fail[g] = sof;
    start[g] = 1'b1;
    @(posedge clk);
    #1;
    start[g] = 1'b0;
    stop_on_fail[g] = ~sof;
    n = 0; nb = 0;
    while (done[g] !== 1'b1 && n < 3000) begin
      @(negedge clk);
      if (done[g] !== 1'b1) begin n++; if (busy[g] !== 1'b1) nb++; end
    end
    @(negedge clk);
    check({tag, "_done"},     done[g], 1'b1);
    check({tag, "_busy"},     busy[g], 1'b0);
    check({tag, "_cycles"},   n, m.cycles);
    check({tag, "_busyrun"},  nb, 0);
    check({tag, "_vecs"},     vec_count[g], m.vecs);
    check({tag, "_fails"},    fail_count[g], m.fails);
    check({tag, "_pass"},     pass[g], m.pass);
    check({tag, "_overrun"},  overrun[g], m.overrun);
    check({tag, "_faddr"},    fail_addr[g], m.faddr);
    check({tag, "_fexp"},     fail_expected[g], m.fexp);
    check({tag, "_fact"},     fail_actual[g], m.fact);
    check({tag, "_pulses"},   pulses[g] - p0, m.pulses);
    check({tag, "_stim"},     stim_bad[g] - b0, 0);
  endtask

  task automatic check_reset_state(input int g, input string tag);
    check({tag, "_status"}, {busy[g], done[g], pass[g], overrun[g], dut_valid[g], rom_en[g]}, 0);
    check({tag, "_addr"},   rom_addr[g], 0);
    check({tag, "_stim"},   {dut_handle[g], dut_index[g], dut_value[g], dut_selector[g]}, 0);
    check({tag, "_cnt"},    {vec_count[g], fail_count[g]}, 0);
    check({tag, "_cap"},    {fail_addr[g], fail_expected[g], fail_actual[g]}, 0);
    check({tag, "_state"},  state[g], 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [63:0] w;
    int n, found;
    reset = 1'b1;
    for (int g = 0; g < 2; g++) begin
      start[g] = 1'b0; stop_on_fail[g] = 1'b0; rom_busy[g] = 1'b0;
      fill_eop(g);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_reset_state(0, "rst_a");
    check_reset_state(1, "rst_b");

    // start while the ROM is still resetting is dropped, not queued
    rom_busy[0] = 1'b1; start[0] = 1'b1;
    repeat (5) @(negedge clk);
    check("rombusy_state", state[0], 0);
    check("rombusy_busy", busy[0], 1'b0);
    rom_busy[0] = 1'b0; start[0] = 1'b0;
    repeat (3) @(negedge clk);
    check("rombusy_noqueue", {busy[0], done[0]}, 0);

    // three matching vectors then end marker at 0x18
    fill_eop(0);
    for (int k = 0; k < 3; k++) mem[0][k] = good(1'b0);
    run(0, 1'b0, "t1");

    // vector 1 mismatches in value, stop on fail
    fill_eop(0);
    for (int k = 0; k < 4; k++) mem[0][k] = good(1'b0);
    mem[0][1] = mk(1'b0, 1'b0, 8'h01, 8'h00, 8'h2A, 8'h00, 1'b1, 8'h2A);
    run(0, 1'b1, "t2");
    repeat (4) @(negedge clk);
    check("t2_hold_done", done[0], 1'b1);
    check("t2_hold_vecs", {vec_count[0], fail_addr[0]}, {16'd2, 32'h8});

    // continue mode with a second (bool) mismatch at 0x10
    w = mem[0][2]; w[1] = ~w[1]; mem[0][2] = w;
    run(0, 1'b0, "t3");

    // randomized programs: mutating and corrupted vectors mixed in
    for (int rep = 0; rep < 4; rep++) begin
      fill_eop(0);
      n = $urandom_range(2, 8);
      for (int k = 0; k < n; k++) begin
        w = good($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 2) == 0) w[$urandom_range(40, 47)] = ~w[$urandom_range(40, 47)];
        if ($urandom_range(0, 4) == 0) w[1] = ~w[1];
        mem[0][k] = w;
      end
      run(0, bit'($urandom_range(0, 1)), $sformatf("rnd%0d", rep));
    end

    // no end marker below a 0x20 limit
    for (int k = 0; k < 8; k++) mem[1][k] = good(1'b0);
    run(1, 1'b0, "ovr");

    // all mutating with wrong expectations: never compared
    fill_eop(1);
    for (int k = 0; k < 3; k++) begin
      w = good(1'b1); w[1] = ~w[1]; mem[1][k] = w;
    end
    run(1, 1'b1, "mut");

    // reset in SETTLE of the second vector, then rerun from address 0
    fill_eop(0);
    for (int k = 0; k < 4; k++) mem[0][k] = good(1'b0);
    @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    found = 0;
    for (int c = 0; c < 200 && found == 0; c++) begin
      @(negedge clk);
      if (state[0] === 3'd3 && rom_addr[0] !== 32'h0) found = 1;
    end
    check("midrst_reach", found, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_reset_state(0, "midrst");
    @(negedge clk);
    reset = 1'b0;
    run(0, 1'b0, "rerun");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/esfa_vector_runner.md
# esfa_vector_runner

Parametrised, ROM-driven self-test sequencer for the ESFA datapath. It fetches fixed-format test vectors from an external block ROM and applies the stimulus fields to the ESFA design under test. For each non-mutating vector it compares the DUT result against the expected bool and value, and reports pass/fail, vector and failure counts, and a capture of the first failing vector. It sits between the board-level start control, the block ROM and the ESFA design, with configurable ROM/DUT latency and a stop-on-fail or continue mode.

## Interface
Parameters:
- DATA_W, 8: width of each ESFA field (handle, index, value, selector, expected value).
- ROM_W, 64: ROM word width; must be ≥ 8+5*DATA_W.
- ADDR_W, 32: ROM address width.
- ADDR_STEP, 8: address increment per vector.
- ADDR_LIMIT, 32'h0000_1000: first address treated as overrun.
- ROM_LAT, 2: cycles from a stable rom_addr to valid rom_data (≥1).
- DUT_LAT, 1: cycles from dut_valid to a valid DUT result (≥1).
- CNT_W, 16: width of the vector and failure counters.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  run request, sampled in IDLE/DONE.
- stop_on_fail  in  1  mode, latched when start is accepted.
- rom_busy  in  1  ROM reset in progress; blocks start.
- rom_en  out  1  ROM read enable.
- rom_addr  out  ADDR_W  vector address.
- rom_data  in  ROM_W  vector word.
- dut_handle, dut_index, dut_value, dut_selector  out  DATA_W each  stimulus, registered.
- dut_valid  out  1  one-cycle stimulus strobe.
- dut_result_bool  in  1; dut_result_value  in  DATA_W  DUT response.
- busy, done, pass, overrun  out  1 each  status.
- vec_count, fail_count  out  CNT_W  saturating counters.
- fail_addr  out  ADDR_W; fail_expected, fail_actual  out  DATA_W+1  first failure capture, as {bool, value}.

## Operation
- Vector fields:
  - bit0 mutating; bit1 expected bool; bit2 end-of-program.
  - [8 +: DATA_W] handle, then index, selector position order: handle, index, value, selector, expected value, each DATA_W and packed contiguously upward.
- States: IDLE, FETCH, APPLY, SETTLE, CHECK, DONE.
- IDLE/DONE, start=1 and rom_busy=0:
  - rom_addr←0; clear the counters, captures and overrun; pass←1; latch stop_on_fail; go to FETCH.
  - start while rom_busy=1 is ignored, not queued.
- FETCH: rom_en=1 and rom_addr held for ROM_LAT cycles, then rom_data is sampled.
  - End-of-program set: go to DONE; the vector is not applied or counted.
  - Otherwise register the stimulus and go to APPLY.
- APPLY: dut_valid=1 for exactly one cycle; go to SETTLE.
- SETTLE: wait DUT_LAT cycles; go to CHECK.
- CHECK:
  - vec_count++.
  - Non-mutating vector with a mismatch in bool or value: fail_count++, pass←0.
    - On the first failure only, capture fail_addr, fail_expected and fail_actual.
    - If stop_on_fail is latched, go to DONE.
  - Otherwise rom_addr += ADDR_STEP. If the new address is ≥ ADDR_LIMIT: overrun←1, pass←0, go to DONE; else go to FETCH.
  - Mutating vectors are never compared.
- DONE: done=1; all results held until the next accepted start or reset.
- Counters saturate at all-ones and never wrap.
- start while busy is ignored.

## Timing
- Reset values:
  - busy=0, done=0, pass=0, overrun=0, dut_valid=0, rom_en=0.
  - rom_addr=0; stimulus outputs 0; counters and captures 0.
  - State is IDLE.
- Reset asserted mid-run returns everything to the reset values at the next edge; no partial result survives.
- busy=1 from the cycle after start is accepted until entering DONE. done rises the same cycle busy falls.
- Cost per vector: ROM_LAT+DUT_LAT+2 cycles.
- The end marker reaches DONE ROM_LAT cycles after its FETCH begins.
- rom_addr changes only on the CHECK→FETCH transition.

## Structure
- Package esfa_pkg:
  - state enum.
  - field-offset localparams: MUT_BIT, EXP_BOOL_BIT, EOP_BIT, FIELD_BASE.
  - a function returning the offset of field k.
- Sub-module esfa_wait_counter: loadable down-counter with a zero flag, reused for the FETCH and SETTLE waits.
- Remaining logic: one FSM plus datapath registers, in esfa_vector_runner.

## Test plan
- Defaults; ROM = 3 matching non-mutating vectors, then an end marker at 0x18 → done after 3·5+2 cycles, pass=1, vec_count=3, fail_count=0.
- Vector 1 at 0x08 expects {1,0x2A}, DUT returns {1,0x2B}, stop_on_fail=1 → done, pass=0, fail_addr=0x08, fail_expected=0x12A, fail_actual=0x12B, vec_count=2.
- Same ROM with stop_on_fail=0 plus a second mismatch at 0x10 → runs to the end marker, fail_count=2, capture still 0x08.
- ROM has no end marker, ADDR_LIMIT=0x20 → overrun=1, pass=0, vec_count=4.
- start held while rom_busy=1 → stays IDLE; reset asserted during SETTLE → all outputs at reset values next cycle; a later start reruns from address 0.
- ROM_LAT=3, DUT_LAT=2, all vectors mutating → no compares, pass=1, 7 cycles per vector, exactly one dut_valid pulse per vector.
